// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder unit for the EX stage: restoring division on
// operand magnitudes with RISC-V sign, divide-by-zero and overflow handling.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    input  logic            hold_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            negQ_q, negQ_d;
    logic            negR_q, negR_d;
    logic            isRem_q, isRem_d;

    logic            isSigned, aNeg, bNeg;
    logic [XLEN-1:0] aMag, bMag;
    logic [XLEN:0]   remShift, trial;
    logic [XLEN-1:0] remNext, quoNext, remFinal, quoFinal;
    logic            busyC, doneC;

    // Operand magnitudes for a new request, and one restoring-division step.
    // The shifted remainder is XLEN+1 bits wide so large unsigned divisors work.
    always_comb begin
        isSigned = ~op_i[0];
        aNeg     = isSigned & a_i[XLEN-1];
        bNeg     = isSigned & b_i[XLEN-1];
        aMag     = aNeg ? -a_i : a_i;
        bMag     = bNeg ? -b_i : b_i;
        remShift = {rem_q, quo_q[XLEN-1]};
        trial    = remShift - {1'b0, dvsr_q};
        remNext  = trial[XLEN] ? remShift[XLEN-1:0] : trial[XLEN-1:0];
        quoNext  = {quo_q[XLEN-2:0], ~trial[XLEN]};
        quoFinal = negQ_q ? -quoNext : quoNext;
        remFinal = negR_q ? -remNext : remNext;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        isRem_d  = isRem_q;
        busyC    = 1'b0;
        doneC    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    busyC   = 1'b1;
                    isRem_d = op_i[1];
                    negQ_d  = aNeg ^ bNeg;
                    negR_d  = aNeg;
                    dvsr_d  = bMag;
                    rem_d   = '0;
                    quo_d   = aMag;
                    cnt_d   = '0;
                    // Corner cases resolve in one cycle without iterating.
                    if (b_i == '0) begin
                        result_d = op_i[1] ? a_i : '1;
                        state_d  = DONE;
                    end else if (isSigned && a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1) begin
                        result_d = op_i[1] ? '0 : a_i;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    busyC = 1'b1;
                    rem_d = remNext;
                    quo_d = quoNext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_d = isRem_q ? remFinal : quoFinal;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    doneC = 1'b1;
                    if (!hold_i) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            isRem_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            isRem_q  <= isRem_d;
        end
    end

    assign busy_o   = busyC & ~rst;
    assign done_o   = doneC;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed, table-driven bench for div_sequencer with hand-written kill, hold
// and mid-operation reset sequences.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        hold;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    div_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .kill_i   (kill),
        .hold_i   (hold),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one operation at a falling edge and follow it to the done pulse.
    task automatic applyStimulus(input string name, input logic [1:0] vOp, input logic [31:0] vA,
                                 input logic [31:0] vB, input logic [31:0] exp, input int lat);
        int cycles;
        logic busyOk;
        @(negedge clk);
        start = 1'b1;
        op    = vOp;
        a     = vA;
        b     = vB;
        #1;
        checkOutput({name, "_busyT"}, {31'd0, busy}, 32'd1);
        cycles = 0;
        busyOk = 1'b1;
        while (!done && cycles < 100) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (!done && !busy) busyOk = 1'b0;
        end
        checkOutput({name, "_latency"}, cycles, lat);
        checkOutput({name, "_result"}, result, exp);
        checkOutput({name, "_busyRun"}, {31'd0, busyOk}, 32'd1);
        checkOutput({name, "_busyDone"}, {31'd0, busy}, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        int cycles;
        int doneCount;
        logic sawDone;

        vecs[0]  = '{"divu_100_7",    2'b01, 32'd100,       32'd7,         32'd14,        33};
        vecs[1]  = '{"remu_100_7",    2'b11, 32'd100,       32'd7,         32'd2,         33};
        vecs[2]  = '{"div_m100_7",    2'b00, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33};
        vecs[3]  = '{"rem_m100_7",    2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33};
        vecs[4]  = '{"div_100_m7",    2'b00, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
        vecs[5]  = '{"rem_100_m7",    2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         33};
        vecs[6]  = '{"divu_by0",      2'b01, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[7]  = '{"rem_by0",       2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 1};
        vecs[8]  = '{"div_ovf",       2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{"rem_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[10] = '{"divu_nonovf",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[11] = '{"divu_max_1",    2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        vecs[12] = '{"remu_big",      2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         33};
        vecs[13] = '{"div_m7_m7",     2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1,         33};
        vecs[14] = '{"rem_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[15] = '{"divu_0_5",      2'b01, 32'd0,         32'd5,         32'd0,         33};

        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd7;
        kill  = 1'b0;
        hold  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // hold during DONE with start still asserted
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd3;
        cycles = 0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        checkOutput("hold_latency", cycles, 33);
        doneCount = done ? 1 : 0;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) doneCount++;
            checkOutput("hold_result", result, 32'd3);
            checkOutput("hold_busy", {31'd0, busy}, 32'd0);
        end
        hold  = 1'b0;
        start = 1'b0;
        checkOutput("hold_doneCycles", doneCount, 4);
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_exit_done", {31'd0, done}, 32'd0);
        checkOutput("hold_exit_busy", {31'd0, busy}, 32'd0);

        // kill at CALC iteration 10, then a fresh divide
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd7;
        sawDone = 1'b0;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        kill = 1'b1;
        #1;
        checkOutput("kill_busy", {31'd0, busy}, 32'd0);
        checkOutput("kill_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        kill  = 1'b0;
        start = 1'b0;
        #1;
        if (done) sawDone = 1'b1;
        checkOutput("kill_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("kill_noDone", {31'd0, sawDone}, 32'd0);
        checkOutput("kill_result_kept", result, 32'd3);
        applyStimulus("divu_9_3_after_kill", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("divu_after_reset", 2'b01, 32'd100, 32'd7, 32'd14, 33);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller and datapath for RV32M DIV/DIVU/REM/REMU in the EX stage. Accepts an operation while the divide instruction sits in EX, runs a 32-iteration restoring division on operand magnitudes, applies RISC-V sign and corner-case rules, and returns the result. Its `busy` output drives the hazard unit's `div_busy_e`, which freezes the front of the pipeline until the result is ready.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals XLEN.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level: valid divide/remainder instruction present in EX.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start` in IDLE.
- `a`  in  XLEN  dividend (rs1), sampled with `start` in IDLE.
- `b`  in  XLEN  divisor (rs2), sampled with `start` in IDLE.
- `kill`  in  1  flush of EX (branch taken); aborts any operation.
- `hold`  in  1  pipeline held by another source (load-use or cache stall); EX instruction will not advance this cycle.
- `busy`  out  1  stall request to hazard unit (`div_busy_e`).
- `done`  out  1  `result` valid for the instruction in EX.
- `result`  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if `start && !kill`: latch op, signedness, sign(a), sign(b), |a|, |b| (magnitudes only for DIV/REM), clear remainder register and iteration counter.
  - `b == 0`: quotient = all ones, remainder = a; go to DONE.
  - DIV/REM with a = 0x8000_0000 and b = 0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0; go to DONE.
  - otherwise go to CALC.
- CALC: one iteration per cycle: shift {rem, quo} left 1; trial = rem − |b| at XLEN+1 bits; if trial non-negative, rem = trial[XLEN-1:0], quo[0] = 1. Counter 0..XLEN-1; after iteration XLEN-1 go to DONE.
- Entering DONE from CALC: signed ops negate quotient when sign(a) ≠ sign(b); remainder takes sign(a) (negate when a negative). Unsigned ops take raw values. `result` register loaded with the selected value.
- DONE: `done = 1`. If `hold`, stay in DONE (result stable, no new sampling even though `start` still high). If `!hold`, go to IDLE; instruction leaves EX at this edge.
- `kill` in any state: next state IDLE, `done` not asserted for aborted op; `start` ignored in that cycle. `kill` outranks `hold`.
- `busy` (combinational): 1 in IDLE when `start && !kill`; 1 throughout CALC unless `kill`; 0 in DONE.
- `result` holds its last value in IDLE/CALC; only updated on entry to DONE.

## Timing
- Reset: state IDLE, `done` = 0, `result` = 0, counter = 0; `busy` forced 0 while `rst` high.
- Normal op, `start` seen in IDLE at cycle T: `busy` high T..T+32, CALC T+1..T+32, DONE at T+33 with `done` = 1, `busy` = 0.
- Corner-case op (divide by zero, signed overflow): `busy` high at T only, DONE at T+1.
- DONE lasts 1 cycle plus one per cycle `hold` is high.
- Back-to-back divides: next `start` accepted no earlier than the IDLE cycle after DONE.
- Reset mid-CALC: immediate return to IDLE, outputs to reset values.

## Test plan
- DIVU 100/7, start at T -> busy T..T+32, done at T+33, result = 14; REMU same operands -> 2.
- DIV 0xFFFF_FF9C(−100)/7 -> 0xFFFF_FFF2(−14); REM same -> 0xFFFF_FFFE(−2); DIV 100/0xFFFF_FFF9 -> 0xFFFF_FFF2.
- DIVU 0x1234/0 -> done at T+1, result 0xFFFF_FFFF; REM 0x1234/0 -> 0x1234.
- DIV 0x8000_0000/0xFFFF_FFFF -> done at T+1, result 0x8000_0000; REM -> 0.
- `kill` at CALC iteration 10 -> busy 0 that cycle, IDLE next, no done pulse; new DIVU 9/3 then completes with 3 after 33 cycles.
- `hold` high 3 cycles during DONE with `start` still high -> done high 4 cycles, result constant, no restart; IDLE after hold drops.
